// File: rtl/uart_word_tx_if.sv
// Word handshake between a producer and uart_word_tx.
// Acceptance is word_valid & word_ready at a rising clock edge.
interface uart_word_tx_if;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;

  modport master (
    output word_valid,
    output word_data,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_data,
    output word_ready
  );
endinterface

// File: rtl/uart_word_tx.sv
// 32-bit word to 8N1 UART serialiser, bytes MSB first,
// four back-to-back frames per word with a one-cycle done pulse.
module uart_word_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  uart_word_tx_if.slave  word_if,
  output logic           uart_txd,
  output logic           tx_busy,
  output logic           tx_done
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam logic [15:0] TICK_LAST = 16'(BPS_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state, state_n;
  logic [15:0] tick_cnt, tick_n;
  logic [2:0]  bit_idx, bit_n;
  logic [1:0]  byte_idx, byte_n;
  logic [31:0] shreg, shreg_n;
  logic        txd_n;
  logic        busy_n;
  logic        done_n;
  logic        ready;
  logic        accept;
  logic        tick_last;
  logic [7:0]  cur_byte;

  // Gated by reset so nothing can look accepted while held in reset
  assign ready = (state == IDLE) & sys_rst_n;
  assign word_if.word_ready = ready;
  assign accept = word_if.word_valid & ready;
  assign tick_last = (tick_cnt == TICK_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      shreg    <= shreg_n;
      uart_txd <= txd_n;
      tx_busy  <= busy_n;
      tx_done  <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    bit_n    = bit_idx;
    byte_n   = byte_idx;
    shreg_n  = shreg;
    done_n   = 1'b0;
    tick_n   = '0;
    txd_n    = 1'b1;
    cur_byte = '0;

    if (state != IDLE) begin
      tick_n = tick_last ? 16'd0 : tick_cnt + 16'd1;
    end

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = START;
          shreg_n = word_if.word_data;
          bit_n   = '0;
          byte_n  = '0;
        end
      end
      START: begin
        if (tick_last) begin
          state_n = DATA;
        end
      end
      DATA: begin
        if (tick_last) begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            bit_n   = '0;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick_last) begin
          if (byte_idx == 2'd3) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = START;
            byte_n  = byte_idx + 2'd1;
            shreg_n = {shreg[23:0], 8'h00};
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is derived from the next state so txd stays a pure flop
    cur_byte = shreg_n[31:24];
    unique case (1'b1)
      (state_n == START): txd_n = 1'b0;
      (state_n == DATA):  txd_n = cur_byte[bit_n];
      default:            txd_n = 1'b1;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: whole-word frame model, per-cycle compare,
// behavioural loopback receiver and directed boundary cases.
module tb_uart_word_tx;

  localparam int BPS      = 16;
  localparam int WORD_CYC = 40 * BPS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic uart_txd;
  logic tx_busy;
  logic tx_done;

  uart_word_tx_if wif ();

  uart_word_tx #(
    .CLK_FREQ(16),
    .UART_BPS(1)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .word_if  (wif.slave),
    .uart_txd (uart_txd),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Line level c cycles into a word: 4 frames of 10 bits each
  function automatic logic frame_bit(input logic [31:0] w,
                                     input int c);
    int bp, k, j;
    logic [7:0] b;
    bp = c / BPS;
    k  = bp / 10;
    j  = bp % 10;
    b  = 8'(w >> (24 - 8 * k));
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  // Reference model: a word is active for WORD_CYC cycles
  logic        m_active = 1'b0;
  logic        m_done   = 1'b0;
  logic [31:0] m_word   = '0;
  int          m_c      = 0;
  int          n_acc    = 0;
  logic        rx_en    = 1'b0;
  logic        cmp_en   = 1'b0;
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_words[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_c      = 0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        if (m_c == WORD_CYC - 1) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_c++;
        end
      end else if (wif.word_valid === 1'b1) begin
        m_active = 1'b1;
        m_c      = 0;
        m_word   = wif.word_data;
        n_acc++;
        if (rx_en) begin
          for (int k = 0; k < 4; k++)
            exp_bytes.push_back(8'(m_word >> (24 - 8 * k)));
          exp_words.push_back(m_word);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("txd", uart_txd,
            m_active ? frame_bit(m_word, m_c) : 1'b1);
      check("busy", tx_busy, m_active);
      check("done", tx_done, m_done);
      if (rst_n) check("ready", wif.word_ready, !m_active);
    end
  end

  // Behavioural receiver, samples mid-bit, assembles at the LSB
  int          rx_bytes = 0;
  int          rx_nb    = 0;
  logic [7:0]  rb;
  logic [31:0] rx_word  = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rx_en && rst_n && uart_txd === 1'b0) begin
        repeat (8) @(negedge clk);
        check("rx_start", uart_txd, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          rb[i] = uart_txd;
        end
        repeat (16) @(negedge clk);
        check("rx_stop", uart_txd, 1'b1);
        rx_bytes++;
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_byte: got %h, expected none", rb);
        end else begin
          check("rx_byte", rb, exp_bytes.pop_front());
        end
        rx_word = {rx_word[23:0], rb};
        rx_nb++;
        if (rx_nb == 4) begin
          rx_nb = 0;
          if (exp_words.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_word: got %h, expected none",
                     rx_word);
          end else begin
            check("rx_word", rx_word, exp_words.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] w);
    int t;
    t = 0;
    wif.word_valid = 1'b1;
    wif.word_data  = w;
    while (wif.word_ready !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready=%b, expected 1",
               wif.word_ready);
    end
    @(posedge clk);
    @(negedge clk);
    wif.word_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (tx_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles",
               tx_done, n);
    end
  endtask

  logic [9:0]  a5_exp;
  logic [31:0] w;
  int          n, n2, acc0, base, idle_low, idle_done;

  initial begin
    a5_exp = 10'b1101001010;
    wif.word_valid = 1'b0;
    wif.word_data  = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;

    // Reset state, offered word must be ignored in reset
    check("rst_txd", uart_txd, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    wif.word_valid = 1'b1;
    wif.word_data  = 32'h5555AAAA;
    repeat (3) @(negedge clk);
    check("rst_busy_valid", tx_busy, 1'b0);
    wif.word_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", wif.word_ready, 1'b1);
    check("rel_txd", uart_txd, 1'b1);

    // Idle line
    idle_low  = 0;
    idle_done = 0;
    repeat (1000) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) idle_low++;
      if (tx_done !== 1'b0) idle_done++;
    end
    check("idle_low_cycles", idle_low, 0);
    check("idle_done_cycles", idle_done, 0);

    // Model pins
    for (int i = 0; i < 10; i++)
      check("model_a5", frame_bit(32'hA55A0F01, i * BPS + 8),
            a5_exp[i]);
    check("model_b3_start", frame_bit(32'hA55A0F01, 30 * BPS), 1'b0);
    check("model_b3_lsb", frame_bit(32'hA55A0F01, 31 * BPS), 1'b1);

    // Single word, mid-bit samples of the first frame
    rx_en = 1'b1;
    send(32'hA55A0F01);
    check("start_latency", uart_txd, 1'b0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("a5_bit", uart_txd, a5_exp[i]);
      repeat (16) @(negedge clk);
    end
    wait_done(n);
    check("single_done_cycle", 168 + n, WORD_CYC);
    @(negedge clk);

    // Valid held while busy with changing data
    send(32'h11223344);
    acc0 = n_acc;
    wif.word_valid = 1'b1;
    repeat (100) begin
      wif.word_data = $urandom;
      @(negedge clk);
    end
    check("busy_ready", wif.word_ready, 1'b0);
    wif.word_valid = 1'b0;
    wait_done(n);
    check("busy_no_accept", n_acc, acc0);
    repeat (5) @(negedge clk);

    // Back-to-back
    send(32'h00000000);
    wif.word_valid = 1'b1;
    wif.word_data  = 32'hFFFFFFFF;
    wait_done(n);
    check("b2b_first", n, WORD_CYC);
    @(negedge clk);
    check("b2b_gap_start", uart_txd, 1'b0);
    wif.word_valid = 1'b0;
    wait_done(n2);
    check("b2b_total", n + 1 + n2, 2 * WORD_CYC + 1);
    repeat (5) @(negedge clk);

    // Reset during byte 2, bit 3 (bit period 24)
    rx_en = 1'b0;
    send(32'hCAFE00EF);
    repeat (24 * BPS + 5) @(negedge clk);
    check("pre_rst_txd", uart_txd, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_txd", uart_txd, 1'b1);
    check("mid_rst_busy", tx_busy, 1'b0);
    check("mid_rst_done", tx_done, 1'b0);
    wif.word_valid = 1'b1;
    wif.word_data  = 32'h0BADF00D;
    repeat (4) @(negedge clk);
    wif.word_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_txd", uart_txd, 1'b1);
    exp_bytes.delete();
    exp_words.delete();
    rx_nb = 0;
    rx_en = 1'b1;
    send(32'h12345678);
    wait_done(n);
    check("post_rst_done", n, WORD_CYC);
    repeat (5) @(negedge clk);

    // Loopback with random words and gaps
    base = rx_bytes;
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      w = $urandom;
      send(w);
      wait_done(n);
      check("loop_done", n, WORD_CYC);
    end
    repeat (20) @(negedge clk);
    check("loop_rx_count", rx_bytes - base, 12);
    check("pending_bytes", exp_bytes.size(), 0);
    check("pending_words", exp_words.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115200, baud rate; local constant BPS_CNT = CLK_FREQ/UART_BPS, integer division (434 at defaults).
REQ-003 SHALL have port sys_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port word_valid  input  1  a 32-bit word is offered for transmission.
REQ-006 SHALL have port word_data  input  32  word to transmit; sampled only on acceptance.
REQ-007 SHALL have port word_ready  output  1  high only in IDLE; acceptance = word_valid & word_ready at a rising edge.
REQ-008 SHALL have port uart_txd  output  1  serial line, 8N1, registered, idle high.
REQ-009 SHALL have port tx_busy  output  1  high from the cycle after acceptance until the frame ends.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse when the last stop bit of a word completes.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, plus a 2-bit byte index (0..3) and a 3-bit bit index (0..7).
REQ-012 SHALL latch word_data into an internal 32-bit shift register on acceptance and ignore word_data and word_valid while not in IDLE.
REQ-013 SHALL transmit bytes most-significant first: word_data[31:24], [23:16], [15:8], [7:0], matching the receive side, which shifts bytes in at the LSB.
REQ-014 SHALL send each byte as start bit (0), 8 data bits LSB first, stop bit (1); no idle gap between the stop bit of one byte and the start bit of the next within a word.
REQ-015 SHALL hold every bit on uart_txd for exactly BPS_CNT sys_clk cycles, timed by a 16-bit tick counter counting 0..BPS_CNT-1 and cleared in IDLE.
REQ-016 SHALL drive uart_txd low on the first rising edge after acceptance (latency 1 cycle).
REQ-017 SHALL make one word occupy exactly 40*BPS_CNT cycles from the first start-bit cycle to the end of the last stop bit.
REQ-018 SHALL transition START->DATA after BPS_CNT ticks; DATA->STOP after bit index 7 completes; STOP->START when byte index < 3 (byte index increments); STOP->IDLE when byte index = 3.
REQ-019 SHALL, on the STOP->IDLE edge, assert tx_done for exactly one cycle, deassert tx_busy, and raise word_ready in that same cycle.
REQ-020 SHALL support back-to-back words: a word_valid held high during the tx_done cycle is accepted, and its start bit begins on the next edge, giving at most 1 idle-high cycle between words.
REQ-021 SHALL keep uart_txd high in IDLE, with no glitches; uart_txd comes directly from a flip-flop.
REQ-022 SHALL treat BPS_CNT < 2 as unsupported; no behaviour is defined for it.

Reset
REQ-023 SHALL on sys_rst_n low asynchronously force: state IDLE, uart_txd=1, tx_busy=0, tx_done=0, word_ready=1 after release, and all counters and the shift register to 0.
REQ-024 SHALL, if reset is asserted mid-word, abort immediately with the line high; no partial byte resumes after release, and the next accepted word starts from byte 0.
REQ-025 SHALL accept no word while sys_rst_n is low.

Verification (CLK_FREQ=16, UART_BPS=1, so BPS_CNT=16)
REQ-026 SHALL cover single word: word_data=0xA55A0F01 accepted -> bytes A5,5A,0F,01 on uart_txd; A5 serialises as 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), 16 cycles per bit; tx_done pulse 640 cycles after the first start bit.
REQ-027 SHALL cover the handshake: word_valid high while busy with changing word_data -> no acceptance, word_ready=0, transmitted word unchanged.
REQ-028 SHALL cover back-to-back: 0x00000000 then 0xFFFFFFFF with valid held -> second start bit begins 1 cycle after tx_done; 1280 cycles total plus 1 gap cycle.
REQ-029 SHALL cover reset mid-word: sys_rst_n low during byte 2, bit 3 -> uart_txd=1 in the same cycle, tx_busy=0; after release, word 0x12345678 transmits 12,34,56,78 from the start.
REQ-030 SHALL cover loopback: uart_txd connected to the existing receiver with matching parameters; send 3 words -> received bytes and assembled 32-bit words equal the sent words, and uart_done fires 12 times.
REQ-031 SHALL cover idle: no word_valid for 1000 cycles after reset -> uart_txd constant 1, tx_done never asserted.
